// File: rtl/wwfa_arbiter_4x4.sv
// -----------------------------------------------------------------------------
// wwfa_arbiter_4x4
//
// Wrapped Wavefront Arbiter core for a 4x4 crossbar. A request matrix is
// latched together with the starting priority diagonal. The four wrapped
// diagonals are then swept one per cycle. Every cell on the current diagonal
// whose row and column are still free is granted. The resulting conflict-free
// grant matrix is offered through a valid/ready handshake. After the handshake
// a single shift_work pulse advances the upstream priority shifters.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   req          request matrix, bit i*4+j = input i wants output j
//   req_valid    req is valid
//   req_ready    block can accept a request matrix (IDLE only)
//   prio_diag    one-hot priority diagonal from the shifters
//   shift_work   one-cycle pulse advancing the priority shifters
//   grant        grant matrix, same mapping as req (zero unless grant_valid)
//   grant_valid  grant is valid
//   grant_ready  consumer accepts the grant
// -----------------------------------------------------------------------------
module wwfa_arbiter_4x4 #(
    parameter int N     = 4,
    parameter int REQ_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REQ_W-1:0] req,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N-1:0]     prio_diag,
    output logic             shift_work,
    output logic [REQ_W-1:0] grant,
    output logic             grant_valid,
    input  logic             grant_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2,
        ST_ADV  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [REQ_W-1:0] req_r_q, req_r_d;
    logic [REQ_W-1:0] grant_r_q, grant_r_d;
    logic [N-1:0]     row_busy_q, row_busy_d;
    logic [N-1:0]     col_busy_q, col_busy_d;
    logic [1:0]       wave_q, wave_d;
    logic [1:0]       prio_q, prio_d;
    logic             req_ready_q, req_ready_d;

    logic [1:0]       prio_idx;
    logic [1:0]       cur_diag;
    logic [REQ_W-1:0] win;      // cells granted on the current wave
    logic [REQ_W-1:0] win_t;    // transpose of win, for column reduction
    logic [N-1:0]     row_win;
    logic [N-1:0]     col_win;

    // Lowest set bit of the priority vector; an all-zero vector selects
    // diagonal 0 so a missing priority still yields a defined sweep.
    always_comb begin
        prio_idx = 2'd0;
        if (prio_diag[0])      prio_idx = 2'd0;
        else if (prio_diag[1]) prio_idx = 2'd1;
        else if (prio_diag[2]) prio_idx = 2'd2;
        else if (prio_diag[3]) prio_idx = 2'd3;
    end

    // 2-bit add wraps naturally, giving the mod-4 diagonal index.
    assign cur_diag = prio_q + wave_q;

    // Cells on one wrapped diagonal never share a row or column, so every
    // cell on the active diagonal can be decided in parallel against the
    // busy masks accumulated from earlier waves.
    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                localparam logic [1:0] CELL_DIAG = 2'((gi + gj) % N);
                assign win[gi*N+gj] = (state_q == ST_EVAL)
                                    && (cur_diag == CELL_DIAG)
                                    && req_r_q[gi*N+gj]
                                    && !row_busy_q[gi]
                                    && !col_busy_q[gj];
                assign win_t[gj*N+gi] = win[gi*N+gj];
            end
        end
        for (gi = 0; gi < N; gi++) begin : g_reduce
            assign row_win[gi] = |win[gi*N +: N];
            assign col_win[gi] = |win_t[gi*N +: N];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        req_r_d    = req_r_q;
        grant_r_d  = grant_r_q;
        row_busy_d = row_busy_q;
        col_busy_d = col_busy_q;
        wave_d     = wave_q;
        prio_d     = prio_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_r_d = req;
                    prio_d  = prio_idx;
                    wave_d  = 2'd0;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                grant_r_d  = grant_r_q  | win;
                row_busy_d = row_busy_q | row_win;
                col_busy_d = col_busy_q | col_win;
                wave_d     = wave_q + 2'd1;
                if (wave_q == 2'd3) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (grant_ready) begin
                    state_d = ST_ADV;
                end
            end
            ST_ADV: begin
                grant_r_d  = '0;
                row_busy_d = '0;
                col_busy_d = '0;
                wave_d     = 2'd0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered so that req_ready is low while reset is held and rises one
    // edge after the block settles in IDLE.
    assign req_ready_d = (state_d == ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            req_r_q     <= '0;
            grant_r_q   <= '0;
            row_busy_q  <= '0;
            col_busy_q  <= '0;
            wave_q      <= 2'd0;
            prio_q      <= 2'd0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_r_q     <= req_r_d;
            grant_r_q   <= grant_r_d;
            row_busy_q  <= row_busy_d;
            col_busy_q  <= col_busy_d;
            wave_q      <= wave_d;
            prio_q      <= prio_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign grant_valid = (state_q == ST_HOLD);
    assign grant       = grant_valid ? grant_r_q : '0;
    assign shift_work  = (state_q == ST_ADV);

endmodule

// File: tb/tb_wwfa_arbiter_4x4.sv
module tb_wwfa_arbiter_4x4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req_in;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  prio_in;
    logic        shift_work;
    logic [15:0] grant;
    logic        grant_valid;
    logic        grant_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wwfa_arbiter_4x4 dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req_in),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .prio_diag   (prio_in),
        .shift_work  (shift_work),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready)
    );

    typedef struct {
        logic [15:0] req;
        logic [3:0]  prio;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // 1 when every row and column has at most one grant and grant is a subset of r
    function automatic logic legal(input logic [15:0] g, input logic [15:0] r);
        int rc, cc;
        legal = ((g & ~r) == 16'h0);
        for (int a = 0; a < 4; a++) begin
            rc = 0;
            cc = 0;
            for (int b = 0; b < 4; b++) begin
                rc += int'(g[a*4+b]);
                cc += int'(g[b*4+a]);
            end
            if (rc > 1 || cc > 1) legal = 1'b0;
        end
    endfunction

    task automatic wait_ready(input string name);
        int cnt = 0;
        while (!req_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (!req_ready) check({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    // One full transaction with grant_ready held high.
    task automatic run_txn(input logic [15:0] r, input logic [3:0] p,
                           input logic [15:0] exp, input string name);
        int lat;
        wait_ready(name);
        req_in      = r;
        prio_in     = p;
        req_valid   = 1'b1;
        grant_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // inputs change after acceptance and must be ignored
        req_valid = 1'b0;
        req_in    = ~r;
        prio_in   = ~p;
        lat = 1;
        while (!grant_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd5);
        check({name, "_grant"}, 32'(grant), 32'(exp));
        check({name, "_legal"}, 32'(legal(grant, r)), 32'd1);
        @(negedge clk);
        check({name, "_shift_pulse"}, 32'(shift_work), 32'd1);
        check({name, "_valid_drop"}, 32'(grant_valid), 32'd0);
        check({name, "_grant_zero"}, 32'(grant), 32'd0);
        @(negedge clk);
        check({name, "_shift_end"}, 32'(shift_work), 32'd0);
        check({name, "_ready_back"}, 32'(req_ready), 32'd1);
        $display("[TB] txn %s req=%04h prio=%04b grant=%04h exp=%04h", name, r, p, grant_prev_dummy(exp), exp);
    endtask

    function automatic logic [15:0] grant_prev_dummy(input logic [15:0] v);
        return v;
    endfunction

    initial begin
        int lat;
        int pulses;

        vecs[0]  = '{16'hFFFF, 4'b0001, 16'h2481, "perm_p0"};
        vecs[1]  = '{16'hFFFF, 4'b0010, 16'h4812, "perm_p1"};
        vecs[2]  = '{16'hFFFF, 4'b0100, 16'h8124, "perm_p2"};
        vecs[3]  = '{16'hFFFF, 4'b1000, 16'h1248, "perm_p3"};
        vecs[4]  = '{16'h0003, 4'b0001, 16'h0001, "row_p0"};
        vecs[5]  = '{16'h0003, 4'b0010, 16'h0002, "row_p1"};
        vecs[6]  = '{16'h0003, 4'b1000, 16'h0001, "row_p3"};
        vecs[7]  = '{16'h0011, 4'b0001, 16'h0001, "col_p0"};
        vecs[8]  = '{16'h0011, 4'b0010, 16'h0010, "col_p1"};
        vecs[9]  = '{16'h0000, 4'b0001, 16'h0000, "zero_req"};
        vecs[10] = '{16'hFFFF, 4'b0000, 16'h2481, "prio_none"};
        vecs[11] = '{16'hFFFF, 4'b0110, 16'h4812, "prio_multi"};
        vecs[12] = '{16'h0021, 4'b0100, 16'h0021, "two_diag"};

        reset       = 1'b0;
        req_in      = 16'h0;
        req_valid   = 1'b0;
        prio_in     = 4'b0001;
        grant_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_shift_work", 32'(shift_work), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 13; v++) begin
            run_txn(vecs[v].req, vecs[v].prio, vecs[v].exp, vecs[v].name);
        end

        // Backpressure: grant must hold for 10 stalled cycles, nothing accepted.
        wait_ready("bp");
        req_in      = 16'hFFFF;
        prio_in     = 4'b0100;
        req_valid   = 1'b1;
        grant_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!grant_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd5);
        check("bp_grant", 32'(grant), 32'h8124);
        req_valid = 1'b1;
        req_in    = 16'h0001;
        prio_in   = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_hold_grant", 32'(grant), 32'h8124);
            check("bp_hold_valid", 32'(grant_valid), 32'd1);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            check("bp_hold_shift", 32'(shift_work), 32'd0);
        end
        req_valid   = 1'b0;
        grant_ready = 1'b1;
        pulses = 0;
        @(negedge clk);
        check("bp_shift_pulse", 32'(shift_work), 32'd1);
        pulses += int'(shift_work);
        @(negedge clk);
        pulses += int'(shift_work);
        check("bp_ready_after", 32'(req_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            pulses += int'(shift_work);
        end
        check("bp_single_pulse", 32'(pulses), 32'd1);
        $display("[TB] txn backpressure stall=10 grant=8124 pulses=%0d", pulses);

        // Reset during wave k=2 discards partial grants and busy masks.
        wait_ready("rst_mid");
        req_in    = 16'hFFFF;
        prio_in   = 4'b0001;
        req_valid = 1'b1;
        @(posedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_grant", 32'(grant), 32'd0);
        check("rst_mid_valid", 32'(grant_valid), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd0);
        check("rst_mid_shift", 32'(shift_work), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(shift_work) + int'(grant_valid);
        end
        check("rst_mid_quiet", 32'(pulses), 32'd0);
        $display("[TB] txn reset_mid_eval discarded");
        run_txn(16'h0020, 4'b0001, 16'h0020, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wwfa_arbiter_4x4.md
Name: wwfa_arbiter_4x4

Overview:
- Wrapped Wavefront Arbiter core for the 4x4 crossbar switch.
- Sits directly downstream of the four priority shifters. It consumes their one-hot priority diagonal and returns the WORK advance pulse to them.
- Accepts a 16-bit request matrix (input i wants output j) and evaluates four wrapped diagonals sequentially, one per cycle, starting at the priority diagonal.
- Emits a conflict-free grant matrix (at most one grant per row and per column) through a valid/ready handshake.

Parameters:
- N, 4, switch dimension; only 4 is supported, and diagonal math is mod 4.
- REQ_W, 16, request/grant width; fixed at N*N.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  16  request matrix; bit i*4+j means input i requests output j.
- req_valid  input  1  req is valid.
- req_ready  output  1  block can accept a request matrix.
- prio_diag  input  4  one-hot priority diagonal from the shifters; bit d selects diagonal d.
- shift_work  output  1  one-cycle pulse that advances the priority shifters (drives their WORK input).
- grant  output  16  grant matrix, same bit mapping as req.
- grant_valid  output  1  grant is valid.
- grant_ready  input  1  consumer accepts the grant.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, req_ready=0, grant=0, grant_valid=0, shift_work=0, internal row/col-busy masks=0, wave counter=0.
- FSM states: IDLE, EVAL, HOLD, ADV.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch req into req_r and latch the start diagonal p from prio_diag; go to EVAL with wave k=0.
  - p decoding: index of the lowest set bit of prio_diag; if prio_diag==0, p=0.
- EVAL (exactly 4 cycles, k=0..3):
  - Current diagonal d=(p+k) mod 4.
  - Cell (i,j) is on diagonal d iff (i+j) mod 4 == d.
  - Cell (i,j) is granted iff req_r[i*4+j]=1, row i is not busy, and column j is not busy.
  - Each granted cell sets grant_r bit i*4+j, row_busy[i] and col_busy[j] at the clock edge.
  - Cells on one diagonal never share a row or column, so all cells of a diagonal are decided in the same cycle.
  - After k=3, go to HOLD.
- HOLD:
  - grant_valid=1 and grant=grant_r; grant stays stable while grant_ready=0, with no limit on stall length.
  - On grant_valid&grant_ready: go to ADV.
- ADV (one cycle):
  - shift_work=1 for exactly this cycle.
  - Clear grant_r, row_busy, col_busy and the wave counter; go to IDLE.
- req_ready=0 in EVAL, HOLD and ADV; requests presented there are not accepted.
- grant=0 whenever grant_valid=0.
- Latency: request accepted at edge T0; the four wave updates occur at edges T1..T4; grant_valid=1 from T4 onward, so the first observable grant is in cycle 5 after acceptance. Minimum period between accepted requests is 6 cycles with grant_ready held at 1.
- A zero request matrix still runs the full sequence: the result is grant=0 with grant_valid=1, followed by a shift_work pulse, so priority rotates regardless.
- prio_diag is sampled only on request acceptance; changes during EVAL or HOLD are ignored.
- Reset asserted mid-EVAL or mid-HOLD: all state clears immediately, no shift_work pulse occurs, and partial grants are discarded.
- Invariant: popcount of every row and every column of grant is ≤1, and grant ⊆ req_r.

Test Plan:
- req=16'hFFFF, prio_diag=4'b0001 -> grant=16'h2481 in cycle 5 after acceptance, then shift_work pulses for 1 cycle after the grant handshake.
- req=16'hFFFF, prio_diag=4'b0010 -> grant=16'h4812. Repeat with 4'b0100 and 4'b1000 and check every result is a full permutation.
- Row conflict: req=16'h0003 with prio_diag=4'b0001 -> grant=16'h0001; with prio_diag=4'b0010 -> grant=16'h0002.
- Backpressure: grant_ready held at 0 for 10 cycles -> grant_valid and grant stay stable, req_ready=0, shift_work=0. Raising grant_ready -> a single shift_work pulse, then req_ready=1 the cycle after.
- req=16'h0000 -> grant_valid=1, grant=0, and shift_work still pulses. prio_diag=4'b0000 behaves identically to 4'b0001.
- Assert reset during EVAL wave k=2 -> grant=0, grant_valid=0, req_ready=0 immediately. After release, a fresh req=16'h0020 -> grant=16'h0020.
